// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and constants: state encoding, NOP word, opcode values.
package riscv_pkg;

  localparam int          ADDR_W_DEF = 32;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam logic [6:0]  R_TYPE     = 7'b0110011;
  localparam logic [6:0]  I_FORMAT   = 7'b0010011;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID slot: holds one fetched instruction and exposes its decoded fields as plain slices.
module if_id_reg
  import riscv_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fill,
  input  logic              flush,
  input  logic              consume,
  input  logic [ADDR_W-1:0] fill_pc,
  input  logic [31:0]       fill_instr,
  output logic              id_valid,
  output logic [ADDR_W-1:0] id_pc,
  output logic [31:0]       id_instr,
  output logic [6:0]        opcode,
  output logic [2:0]        func3,
  output logic [6:0]        func7,
  output logic [4:0]        rd,
  output logic [4:0]        rs1,
  output logic [4:0]        rs2
);

  // Flush wins over fill so a response racing a redirect never lands in the slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid <= 1'b0;
      id_pc    <= '0;
      id_instr <= NOP_INSTR;
    end else if (flush) begin
      id_valid <= 1'b0;
    end else if (fill) begin
      id_valid <= 1'b1;
      id_pc    <= fill_pc;
      id_instr <= fill_instr;
    end else if (consume) begin
      id_valid <= 1'b0;
    end
  end

  assign opcode = id_instr[6:0];
  assign rd     = id_instr[11:7];
  assign func3  = id_instr[14:12];
  assign rs1    = id_instr[19:15];
  assign rs2    = id_instr[24:20];
  assign func7  = id_instr[31:25];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC register, single-outstanding fetch FSM and redirect handling
// feeding the IF/ID slot.
module instr_fetch
  import riscv_pkg::*;
#(
  parameter int               ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [ADDR_W-1:0] id_pc,
  output logic [31:0]       id_instr,
  output logic [6:0]        opcode,
  output logic [2:0]        func3,
  output logic [6:0]        func7,
  output logic [4:0]        rd,
  output logic [4:0]        rs1,
  output logic [4:0]        rs2
);

  fetch_state_e      state;
  logic [ADDR_W-1:0] pc;
  logic              live;
  logic              hs;
  logic              fill;
  logic [ADDR_W-1:0] redir_tgt;

  // live keeps the request port quiet while reset is held and for the release edge.
  assign imem_req_valid = live && (state == S_REQ) && (!id_valid || id_ready);
  assign imem_addr      = pc;
  assign hs             = imem_req_valid && imem_req_ready;
  assign fill           = (state == S_WAIT) && imem_rsp_valid && !redirect_valid;
  assign redir_tgt      = redirect_pc & ~ADDR_W'(3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_REQ;
      pc    <= RESET_PC;
      live  <= 1'b0;
    end else begin
      live <= 1'b1;
      if (redirect_valid) begin
        pc <= redir_tgt;
        unique case (state)
          S_REQ:   state <= hs ? S_DRAIN : S_REQ;
          S_WAIT:  state <= imem_rsp_valid ? S_REQ : S_DRAIN;
          S_DRAIN: state <= imem_rsp_valid ? S_REQ : S_DRAIN;
          default: state <= S_REQ;
        endcase
      end else begin
        unique case (state)
          S_REQ: if (hs) state <= S_WAIT;
          S_WAIT:
            if (imem_rsp_valid) begin
              pc    <= pc + ADDR_W'(4);
              state <= S_REQ;
            end
          S_DRAIN: if (imem_rsp_valid) state <= S_REQ;
          default: state <= S_REQ;
        endcase
      end
    end
  end

  if_id_reg #(.ADDR_W(ADDR_W)) u_slot (
    .clk        (clk),
    .rst_n      (rst_n),
    .fill       (fill),
    .flush      (redirect_valid),
    .consume    (id_ready),
    .fill_pc    (pc),
    .fill_instr (imem_rsp_data),
    .id_valid   (id_valid),
    .id_pc      (id_pc),
    .id_instr   (id_instr),
    .opcode     (opcode),
    .func3      (func3),
    .func7      (func7),
    .rd         (rd),
    .rs1        (rs1),
    .rs2        (rs2)
  );

  // A response with nothing outstanding means the memory broke the one-per-request contract.
  a_no_stray_rsp: assert property (@(posedge clk) disable iff (!rst_n)
    !((state == S_REQ) && imem_rsp_valid));

endmodule
